program_loader: RTL and testbench

//  Loads a program from a byte stream into the 16-byte RAM, then hands the machine back to the CPU.

---
 rtl/eater_pkg.sv | 31 +++
 rtl/program_loader.sv | 120 ++++++++++++
 tb/tb_program_loader.sv | 372 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/eater_pkg.sv
// Shared definitions for the 8-bit breadboard CPU: control-word bit constants and the
// program loader state encoding.
// Contents: HLT..FI one-hot control bits, BUS_DRIVERS mask of all *O bits, loader_state_t.
package eater_pkg;

    // Control word bits, MSB first.
    localparam logic [15:0] HLT = 16'h8000;
    localparam logic [15:0] MI  = 16'h4000;
    localparam logic [15:0] RI  = 16'h2000;
    localparam logic [15:0] RO  = 16'h1000;
    localparam logic [15:0] IO  = 16'h0800;
    localparam logic [15:0] II  = 16'h0400;
    localparam logic [15:0] AI  = 16'h0200;
    localparam logic [15:0] AO  = 16'h0100;
    localparam logic [15:0] EO  = 16'h0080;
    localparam logic [15:0] SU  = 16'h0040;
    localparam logic [15:0] BI  = 16'h0020;
    localparam logic [15:0] OI  = 16'h0010;
    localparam logic [15:0] CE  = 16'h0008;
    localparam logic [15:0] CO  = 16'h0004;
    localparam logic [15:0] J   = 16'h0002;
    localparam logic [15:0] FI  = 16'h0001;

    // Every bit that makes a datapath block drive the shared bus.
    localparam logic [15:0] BUS_DRIVERS = RO | IO | AO | EO | CO;

    typedef enum logic [2:0] {
        IDLE, LEN, WAIT, ADDR, DATA, CHK, DONE, ERROR
    } loader_state_t;

endpackage

// File: rtl/program_loader.sv
// Program loader: takes over bus and RAM to write a length-prefixed byte stream into RAM,
// then releases the CPU. Optional trailer checksum when LOADER_CHECKSUM_EN is defined.
// Ports: clk/rst (async, high); load_start; byte_valid/byte_data/byte_ready stream;
// cpu_ctrl in -> ctrl_out; ldr_bus/ldr_bus_oe; cpu_clk_en, cpu_rst, busy, done, error.
module program_loader
    import eater_pkg::*;
#(
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 8,
    parameter int MAX_LEN = 1 << ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic              byte_valid,
    input  logic [DATA_W-1:0] byte_data,
    output logic              byte_ready,
    input  logic [15:0]       cpu_ctrl,
    output logic [15:0]       ctrl_out,
    output logic [DATA_W-1:0] ldr_bus,
    output logic              ldr_bus_oe,
    output logic              cpu_clk_en,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic              error
);

    // One extra bit so a length of exactly MAX_LEN is representable.
    localparam int LEN_W = ADDR_W + 1;

    loader_state_t     state;
    loader_state_t     nxt;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
    logic [DATA_W-1:0] data_q;
    logic [15:0]       ldr_ctrl;
    logic              last;
    logic              len_bad;
`ifdef LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] sum;
`endif

    // Final byte is the one whose address equals len-1; addr therefore never wraps.
    assign last    = ({1'b0, addr} == (len - LEN_W'(1)));
    assign len_bad = (byte_data == '0) || ({1'b0, byte_data} > (DATA_W + 1)'(MAX_LEN));

    // The control unit keeps the datapath while idle; otherwise only loader bits go out.
    assign ctrl_out = (state == IDLE) ? cpu_ctrl : ldr_ctrl;

    always_comb begin
        nxt = state;
        case (state)
            IDLE:  if (load_start) nxt = LEN;
            LEN:   if (byte_valid) nxt = len_bad ? ERROR : WAIT;
            WAIT:  if (byte_valid) nxt = ADDR;
            ADDR:  nxt = DATA;
`ifdef LOADER_CHECKSUM_EN
            DATA:  nxt = last ? CHK : WAIT;
            CHK:   if (byte_valid) nxt = (byte_data == sum) ? DONE : ERROR;
`else
            DATA:  nxt = last ? DONE : WAIT;
`endif
            DONE:  nxt = IDLE;
            ERROR: if (load_start) nxt = LEN;
            default: nxt = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            addr       <= '0;
            len        <= '0;
            data_q     <= '0;
`ifdef LOADER_CHECKSUM_EN
            sum        <= '0;
`endif
            ldr_ctrl   <= '0;
            ldr_bus    <= '0;
            ldr_bus_oe <= 1'b0;
            byte_ready <= 1'b0;
            cpu_clk_en <= 1'b1;
            cpu_rst    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            state <= nxt;

            if (state == LEN && byte_valid && !len_bad) begin
                len  <= LEN_W'(byte_data);
                addr <= '0;
`ifdef LOADER_CHECKSUM_EN
                sum  <= '0;
`endif
            end
            if (state == WAIT && byte_valid) data_q <= byte_data;
            if (state == DATA) begin
                if (!last) addr <= addr + ADDR_W'(1);
`ifdef LOADER_CHECKSUM_EN
                sum <= sum + data_q;
`endif
            end

            // ADDR publishes the current address, DATA the byte latched in WAIT.
            ldr_ctrl   <= (nxt == ADDR) ? MI : (nxt == DATA) ? RI : 16'h0000;
            ldr_bus    <= (nxt == ADDR) ? DATA_W'(addr) : (nxt == DATA) ? data_q : '0;
            ldr_bus_oe <= (nxt == ADDR) || (nxt == DATA);
            byte_ready <= (nxt == LEN) || (nxt == WAIT) || (nxt == CHK);
            cpu_clk_en <= (nxt == IDLE);
            cpu_rst    <= (nxt == DONE);
            done       <= (nxt == DONE);
            busy       <= (nxt != IDLE);
            error      <= (nxt == ERROR);
        end
    end

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

    typedef logic [7:0] bq_t[$];

    localparam logic [15:0] C_MI = 16'h4000;
    localparam logic [15:0] C_RI = 16'h2000;
    localparam logic [15:0] C_OUT_BITS = 16'h1000 | 16'h0800 | 16'h0100 | 16'h0080 | 16'h0004;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_start = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic        byte_ready;
    logic [15:0] cpu_ctrl = 16'h0000;
    logic [15:0] ctrl_out;
    logic [7:0]  ldr_bus;
    logic        ldr_bus_oe;
    logic        cpu_clk_en;
    logic        cpu_rst;
    logic        busy;
    logic        done;
    logic        error;

    int checks = 0;
    int errors = 0;

    // Observed RAM writes, reconstructed from the bus: MI latches an address, RI stores.
    logic [7:0] wr_a[$];
    logic [7:0] wr_d[$];
    logic [7:0] ram[16];
    logic [7:0] mar = 8'h00;
    bit         mar_vld = 0;
    int         done_cnt = 0;
    int         order_err = 0;
    int         contention = 0;

    program_loader dut (
        .clk(clk), .rst(rst), .load_start(load_start), .byte_valid(byte_valid),
        .byte_data(byte_data), .byte_ready(byte_ready), .cpu_ctrl(cpu_ctrl),
        .ctrl_out(ctrl_out), .ldr_bus(ldr_bus), .ldr_bus_oe(ldr_bus_oe),
        .cpu_clk_en(cpu_clk_en), .cpu_rst(cpu_rst), .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            if (busy && (ctrl_out & C_OUT_BITS) != 16'h0000) contention++;
            if (ldr_bus_oe && ctrl_out == C_MI) begin
                mar = ldr_bus;
                mar_vld = 1;
            end else if (ldr_bus_oe && ctrl_out == C_RI) begin
                if (!mar_vld) order_err++;
                ram[mar[3:0]] = ldr_bus;
                wr_a.push_back(mar);
                wr_d.push_back(ldr_bus);
                mar_vld = 0;
            end
            if (done) done_cnt++;
        end
    end

    // Reference stream: length byte, data, and (with checksum) the byte-wise sum trailer.
    function automatic bq_t mk_stream(bq_t d);
        bq_t s;
        logic [7:0] total;
        total = 8'h00;
        s.push_back(8'(d.size()));
        foreach (d[i]) begin
            s.push_back(d[i]);
            total = total + d[i];
        end
`ifdef LOADER_CHECKSUM_EN
        s.push_back(total);
`endif
        return s;
    endfunction

    task automatic clear_log();
        wr_a.delete();
        wr_d.delete();
        done_cnt = 0;
        mar_vld = 0;
    endtask

    task automatic start_load();
        @(posedge clk); #1 load_start = 1'b1;
        @(posedge clk); #1 load_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        repeat (gap) @(posedge clk);
        if (gap > 0) #1;
        byte_valid = 1'b1;
        byte_data  = b;
        n = 0;
        @(negedge clk);
        while (!byte_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (!byte_ready) begin
            errors++;
            $display("FAIL send_byte timeout: byte_ready=%b required 1 within 200 cycles", byte_ready);
        end
        @(posedge clk); #1;
        byte_valid = 1'b0;
        byte_data  = 8'($urandom);
    endtask

    task automatic send_stream(input bq_t s, input bit stall);
        foreach (s[i]) send_byte(s[i], stall ? int'($urandom_range(0, 3)) : 0);
    endtask

    task automatic wait_done(output bit ok);
        ok = 0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            if (done) ok = 1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({byte_ready, ldr_bus, ldr_bus_oe, cpu_clk_en, cpu_rst, busy, done, error} !== {1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset outputs: rdy=%b bus=%h oe=%b clk_en=%b cpu_rst=%b busy=%b done=%b err=%b", byte_ready, ldr_bus, ldr_bus_oe, cpu_clk_en, cpu_rst, busy, done, error);
        end
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic test_idle();
        logic [15:0] v;
        cpu_ctrl = 16'h4004;
        @(negedge clk);
        checks++;
        if (ctrl_out !== 16'h4004) begin
            errors++;
            $display("FAIL idle passthrough: ctrl_out=%h required 4004", ctrl_out);
        end
        for (int i = 0; i < 4; i++) begin
            v = 16'($urandom);
            cpu_ctrl = v;
            #1;
            checks++;
            if (ctrl_out !== v) begin
                errors++;
                $display("FAIL idle passthrough random: ctrl_out=%h required %h", ctrl_out, v);
            end
            @(negedge clk);
        end
        cpu_ctrl = 16'h4004;
    endtask

    task automatic test_normal();
        bq_t d = '{8'h1E, 8'h2F, 8'hE0};
        bit ok;
        clear_log();
        @(posedge clk); #1 load_start = 1'b1;
        @(negedge clk);
        checks++;
        if (cpu_clk_en !== 1'b1) begin
            errors++;
            $display("FAIL clk_en before start sampled: got %b required 1", cpu_clk_en);
        end
        @(posedge clk); #1 load_start = 1'b0;
        @(negedge clk);
        checks++;
        if (cpu_clk_en !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL clk_en after start: clk_en=%b busy=%b required 0/1", cpu_clk_en, busy);
        end
        @(posedge clk); #1;
        send_stream(mk_stream(d), 0);
        wait_done(ok);
        checks++;
        if (!ok || cpu_rst !== 1'b1 || cpu_clk_en !== 1'b0) begin
            errors++;
            $display("FAIL normal done pulse: seen=%b cpu_rst=%b clk_en=%b required 1/1/0", ok, cpu_rst, cpu_clk_en);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || cpu_rst !== 1'b0 || cpu_clk_en !== 1'b1) begin
            errors++;
            $display("FAIL after done: done=%b cpu_rst=%b clk_en=%b required 0/0/1", done, cpu_rst, cpu_clk_en);
        end
        checks++;
        if (wr_a.size() != 3) begin
            errors++;
            $display("FAIL normal write count: got %0d required 3", wr_a.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (wr_a[i] !== 8'(i) || wr_d[i] !== d[i]) begin
                    errors++;
                    $display("FAIL normal write %0d: MI bus=%h RI bus=%h required %h/%h", i, wr_a[i], wr_d[i], 8'(i), d[i]);
                end
            end
        end
    endtask

    task automatic test_bad_length();
        bq_t bad = '{8'h00, 8'h11};
        bq_t d = '{8'hAA, 8'h55};
        bit ok;
        foreach (bad[k]) begin
            start_load();
            send_byte(bad[k], 0);
            @(negedge clk);
            checks++;
            if (error !== 1'b1 || byte_ready !== 1'b0 || cpu_clk_en !== 1'b0) begin
                errors++;
                $display("FAIL bad length %h: error=%b rdy=%b clk_en=%b required 1/0/0", bad[k], error, byte_ready, cpu_clk_en);
            end
        end
        clear_log();
        start_load();
        send_stream(mk_stream(d), 0);
        wait_done(ok);
        checks++;
        if (!ok || error !== 1'b0 || wr_d.size() != 2) begin
            errors++;
            $display("FAIL error recovery: done=%b error=%b writes=%0d required 1/0/2", ok, error, wr_d.size());
        end
        @(negedge clk);
    endtask

    task automatic test_full_stall();
        bq_t d;
        bit ok;
        int zero_writes;
        for (int i = 0; i < 16; i++) d.push_back(8'($urandom));
        clear_log();
        start_load();
        send_stream(mk_stream(d), 1);
        wait_done(ok);
        repeat (3) @(negedge clk);
        checks++;
        if (!ok || done_cnt != 1 || wr_a.size() != 16) begin
            errors++;
            $display("FAIL full load: done_seen=%b done_cnt=%0d writes=%0d required 1/1/16", ok, done_cnt, wr_a.size());
        end
        zero_writes = 0;
        foreach (wr_a[i]) if (wr_a[i] == 8'h00) zero_writes++;
        checks++;
        if (zero_writes != 1) begin
            errors++;
            $display("FAIL full load addr 0 writes: got %0d required 1", zero_writes);
        end
        for (int i = 0; i < 16 && i < wr_a.size(); i++) begin
            checks++;
            if (wr_a[i] !== 8'(i) || wr_d[i] !== d[i]) begin
                errors++;
                $display("FAIL full load write %0d: addr=%h data=%h required %h/%h", i, wr_a[i], wr_d[i], 8'(i), d[i]);
            end
        end
    endtask

    task automatic test_ignore_start_in_wait();
        bq_t d = '{8'h11, 8'h22, 8'h33};
        bq_t s;
        bit ok;
        s = mk_stream(d);
        clear_log();
        start_load();
        send_byte(s[0], 0);
        send_byte(s[1], 0);
        repeat (3) @(posedge clk);
        #1 load_start = 1'b1;
        @(posedge clk); #1 load_start = 1'b0;
        for (int i = 2; i < s.size(); i++) send_byte(s[i], 0);
        wait_done(ok);
        checks++;
        if (!ok || wr_a.size() != 3) begin
            errors++;
            $display("FAIL start in WAIT: done=%b writes=%0d required 1/3", ok, wr_a.size());
        end
        for (int i = 0; i < 3 && i < wr_a.size(); i++) begin
            checks++;
            if (wr_a[i] !== 8'(i) || wr_d[i] !== d[i]) begin
                errors++;
                $display("FAIL start in WAIT write %0d: addr=%h data=%h required %h/%h", i, wr_a[i], wr_d[i], 8'(i), d[i]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_load();
        bq_t s = '{8'h04, 8'h01, 8'h02, 8'h03};
        clear_log();
        start_load();
        foreach (s[i]) send_byte(s[i], 0);
        @(negedge clk);
        checks++;
        if (ldr_bus_oe !== 1'b1 || ctrl_out !== C_MI || ldr_bus !== 8'h02) begin
            errors++;
            $display("FAIL mid-load ADDR phase: oe=%b ctrl=%h bus=%h required 1/4000/02", ldr_bus_oe, ctrl_out, ldr_bus);
        end
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || cpu_clk_en !== 1'b1 || ldr_bus_oe !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset mid-load: busy=%b clk_en=%b oe=%b done=%b required 0/1/0/0", busy, cpu_clk_en, ldr_bus_oe, done);
        end
        @(posedge clk); #1 rst = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (done_cnt != 0 || busy !== 1'b0 || ctrl_out !== cpu_ctrl) begin
            errors++;
            $display("FAIL after mid-load reset: done_cnt=%0d busy=%b ctrl=%h required 0/0/%h", done_cnt, busy, ctrl_out, cpu_ctrl);
        end
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_checksum();
        bq_t good = '{8'h02, 8'h05, 8'h07, 8'h0C};
        bq_t bad  = '{8'h02, 8'h05, 8'h07, 8'h0D};
        bit ok;
        clear_log();
        start_load();
        send_stream(good, 0);
        wait_done(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL checksum good trailer: done=%b required 1", ok);
        end
        ram[0] = 8'h00;
        ram[1] = 8'h00;
        start_load();
        send_stream(bad, 0);
        @(negedge clk);
        checks++;
        if (error !== 1'b1 || ram[0] !== 8'h05 || ram[1] !== 8'h07) begin
            errors++;
            $display("FAIL checksum bad trailer: error=%b ram0=%h ram1=%h required 1/05/07", error, ram[0], ram[1]);
        end
        start_load();
        send_stream(good, 0);
        wait_done(ok);
        @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_idle();
        test_normal();
        test_bad_length();
        test_full_stall();
        test_ignore_start_in_wait();
`ifdef LOADER_CHECKSUM_EN
        test_checksum();
`endif
        test_reset_mid_load();
        checks++;
        if (contention != 0 || order_err != 0) begin
            errors++;
            $display("FAIL bus protocol: contention=%0d order_err=%0d required 0/0", contention, order_err);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
